trng_seq_ctrl: RTL and testbench
================================

TRNG_SEQ_CTRL -- requirements
Module: trng_seq_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, is the number of 32-bit entries in the output FIFO and SHALL be a power of two, at least 2.
REQ-002 Parameter RST_CYCLES, default 2, is the number of cycles o_trng_rst is held during the RESET state.
REQ-003 Parameter REP_LIMIT, default 3, is the count of identical consecutive words that trips the health test.
REQ-004 clk  in  1  clock.
REQ-005 rst_n  in  1  reset; synchronous, active-low.
REQ-006 i_enable  in  1  level; 1 means run sequencing.
REQ-007 i_calib_req  in  1  pulse; request a recalibration.
REQ-008 i_calib_cycles  in  32  calibration length in cycles.
REQ-009 i_pop  in  1  pulse; consume the FIFO head.
REQ-010 i_clr_err  in  1  pulse; clear the health error.
REQ-011 i_trng_ready  in  1  oReady of the TRNG core.
REQ-012 i_trng_random  in  32  random word of the TRNG core.
REQ-013 o_trng_rst, o_trng_en, o_trng_calib, o_trng_read  out  1 each  drive the iRst, iEn, iCalib and iRead inputs of the TRNG core.
REQ-014 o_data  out  32  FIFO head word.
REQ-015 o_valid  out  1  FIFO not empty.
REQ-016 o_count  out  log2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-017 o_state  out  3  current FSM state encoding.
REQ-018 o_err  out  1  sticky health-test failure.
REQ-019 o_irq  out  1  level; asserted when (o_count == FIFO_DEPTH) or o_err.

Function
REQ-020 FSM states SHALL be: IDLE=0, RESET=1, CALIB=2, WAIT=3, READ=4, DRAIN=5, FAULT=6.
REQ-021 IDLE -> RESET when i_enable=1 and o_err=0.
REQ-022 RESET SHALL assert o_trng_rst for exactly RST_CYCLES cycles, then move to CALIB.
REQ-023 CALIB SHALL assert o_trng_en and o_trng_calib for max(i_calib_cycles,1) cycles.
- i_calib_cycles is sampled on entry to CALIB.
- CALIB then moves to WAIT.
REQ-024 WAIT SHALL assert o_trng_en.
- On i_trng_ready=1 with FIFO not full: capture i_trng_random and move to READ.
- On i_trng_ready=1 with FIFO full: remain in WAIT (back-pressure, no capture).
REQ-025 READ SHALL last one cycle with o_trng_read=1 and o_trng_en=1, then move to DRAIN.
- The captured word is pushed into the FIFO in that cycle unless the health test fails.
REQ-026 DRAIN SHALL hold o_trng_en=1 and o_trng_read=0 until i_trng_ready=0, then move to WAIT.
REQ-027 An i_calib_req pulse in WAIT or DRAIN SHALL be latched as pending.
- The pending request is serviced as WAIT -> RESET at the next WAIT cycle in which no capture occurs.
- A request arriving in any other state is latched and serviced at the same point.
REQ-028 Health test on each captured word:
- If the word equals the previous captured word, the repeat counter increments; otherwise the counter is set to 1.
- When the counter reaches REP_LIMIT, the word is not pushed, o_err sets, and the FSM moves from READ to FAULT instead of DRAIN.
REQ-029 FAULT SHALL drive all o_trng_* outputs to 0.
- i_clr_err clears o_err and the repeat counter, then FAULT -> IDLE.
REQ-030 i_enable=0 in any state except FAULT SHALL force IDLE on the next cycle.
- FIFO contents and o_err are retained.
- The repeat counter and the previous-word register are cleared.
REQ-031 FIFO behaviour:
- i_pop with o_valid=1 removes the head; i_pop with o_valid=0 is ignored.
- A simultaneous push and pop leaves o_count unchanged.
- Read and write pointers wrap modulo FIFO_DEPTH.
REQ-032 o_data SHALL equal the head entry combinationally; it is don't-care when o_valid=0.
REQ-033 In IDLE all o_trng_* outputs SHALL be 0.

Reset
REQ-034 On rst_n=0 at a clock edge, the block SHALL enter the following state at the next cycle, regardless of the current state:
- state = IDLE, FIFO empty (o_count=0, o_valid=0), o_err=0, o_irq=0.
- All o_trng_* outputs = 0.
- Repeat counter = 0, calibration counter = 0, pending calibration request = 0.

Verification
REQ-035 i_enable=1, i_calib_cycles=5 -> the bench SHALL observe o_trng_rst=1 for 2 cycles, then o_trng_calib=1 for 5 cycles, then the WAIT state (o_state=3).
REQ-036 Supply ready pulses carrying 0x11, 0x22, 0x33, 0x44, 0x55 with no pops -> o_count=4, o_irq=1, the FSM holds in WAIT, and pops return 0x11, 0x22, 0x33, 0x44 in order.
REQ-037 Three consecutive captures of 0xDEADBEEF -> two words pushed, o_err=1, state FAULT, all o_trng_*=0; i_clr_err -> IDLE, then RESET.
REQ-038 Push and pop in the same cycle with o_count=2 -> o_count stays 2; pop with o_count=0 -> no change.
REQ-039 i_calib_req during DRAIN -> after i_trng_ready falls, the sequence is WAIT -> RESET -> CALIB.
REQ-040 Deassert i_enable in CALIB with 1 word stored -> IDLE next cycle with o_count=1; rst_n=0 mid-READ -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/trng_seq_ctrl.sv
// trng_seq_ctrl: drives a TRNG core through reset, calibration and word
// reads, runs a repetition health test on every captured word and buffers
// accepted words in a small FIFO for software to pop.
module trng_seq_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned RST_CYCLES = 2,
    parameter int unsigned REP_LIMIT  = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_enable,
    input  logic                          i_calib_req,
    input  logic [31:0]                   i_calib_cycles,
    input  logic                          i_pop,
    input  logic                          i_clr_err,
    input  logic                          i_trng_ready,
    input  logic [31:0]                   i_trng_random,
    output logic                          o_trng_rst,
    output logic                          o_trng_en,
    output logic                          o_trng_calib,
    output logic                          o_trng_read,
    output logic [31:0]                   o_data,
    output logic                          o_valid,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic [2:0]                    o_state,
    output logic                          o_err,
    output logic                          o_irq
);
    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam int unsigned RW       = $clog2(REP_LIMIT + 1);
    localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];
    localparam logic [31:0] RST_LOAD = 32'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RESET = 3'd1,
        S_CALIB = 3'd2,
        S_WAIT  = 3'd3,
        S_READ  = 3'd4,
        S_DRAIN = 3'd5,
        S_FAULT = 3'd6
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   cyc_cnt_q, cyc_cnt_d;   // shared RESET / CALIB down-counter
    logic [31:0]   cap_q, cap_d;           // word captured in WAIT
    logic [31:0]   prev_q, prev_d;         // previous captured word
    logic [RW-1:0] rep_q, rep_d;           // identical-word run length
    logic          err_q, err_d;
    logic          pend_q, pend_d;         // pending recalibration request
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   mem_q [FIFO_DEPTH];

    logic          fifo_full;
    logic          push;
    logic          pop;
    logic [RW-1:0] rep_next;
    logic          rep_hit;
    logic [31:0]   calib_load;

    assign fifo_full  = (count_q == FULL_CNT);
    assign pop        = i_pop && (count_q != '0);
    assign rep_next   = ((rep_q != '0) && (cap_q == prev_q)) ? rep_q + RW'(1) : RW'(1);
    assign rep_hit    = (rep_next >= RW'(REP_LIMIT));
    assign calib_load = (i_calib_cycles == 32'd0) ? 32'd0 : i_calib_cycles - 32'd1;

    // Sequencer next-state, health test and push decision.
    // NOTE: every signal assigned below gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        cyc_cnt_d = cyc_cnt_q;
        cap_d     = cap_q;
        prev_d    = prev_q;
        rep_d     = rep_q;
        err_d     = err_q;
        pend_d    = pend_q | i_calib_req;
        push      = 1'b0;

        if (!i_enable && (state_q != S_FAULT)) begin
            // Disable aborts any sequence; FIFO and sticky error survive.
            state_d = S_IDLE;
            rep_d   = '0;
            prev_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!err_q) begin
                        state_d   = S_RESET;
                        cyc_cnt_d = RST_LOAD;
                    end
                end
                S_RESET: begin
                    if (cyc_cnt_q == 32'd0) begin
                        state_d   = S_CALIB;
                        cyc_cnt_d = calib_load;
                    end else begin
                        cyc_cnt_d = cyc_cnt_q - 32'd1;
                    end
                end
                S_CALIB: begin
                    if (cyc_cnt_q == 32'd0) begin
                        state_d = S_WAIT;
                    end else begin
                        cyc_cnt_d = cyc_cnt_q - 32'd1;
                    end
                end
                S_WAIT: begin
                    if (i_trng_ready && !fifo_full) begin
                        cap_d   = i_trng_random;
                        state_d = S_READ;
                    end else if (pend_q) begin
                        // Recalibrate only in a WAIT cycle that captured nothing.
                        pend_d    = i_calib_req;
                        state_d   = S_RESET;
                        cyc_cnt_d = RST_LOAD;
                    end
                end
                S_READ: begin
                    prev_d = cap_q;
                    rep_d  = rep_next;
                    if (rep_hit) begin
                        err_d   = 1'b1;
                        state_d = S_FAULT;
                    end else begin
                        push    = 1'b1;
                        state_d = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!i_trng_ready) begin
                        state_d = S_WAIT;
                    end
                end
                S_FAULT: begin
                    if (i_clr_err) begin
                        err_d   = 1'b0;
                        rep_d   = '0;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // FIFO pointer and occupancy update; pointers wrap naturally at FIFO_DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!push && pop) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    // TRNG core control decoded from the current state.
    always_comb begin
        o_trng_rst   = 1'b0;
        o_trng_en    = 1'b0;
        o_trng_calib = 1'b0;
        o_trng_read  = 1'b0;
        case (state_q)
            S_RESET: o_trng_rst = 1'b1;
            S_CALIB: begin
                o_trng_en    = 1'b1;
                o_trng_calib = 1'b1;
            end
            S_WAIT:  o_trng_en = 1'b1;
            S_READ: begin
                o_trng_en   = 1'b1;
                o_trng_read = 1'b1;
            end
            S_DRAIN: o_trng_en = 1'b1;
            default: ;
        endcase
    end

    // Control and status registers with synchronous active-low reset.
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cyc_cnt_q <= '0;
            cap_q     <= '0;
            prev_q    <= '0;
            rep_q     <= '0;
            err_q     <= 1'b0;
            pend_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            cyc_cnt_q <= cyc_cnt_d;
            cap_q     <= cap_d;
            prev_q    <= prev_d;
            rep_q     <= rep_d;
            err_q     <= err_d;
            pend_q    <= pend_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // FIFO storage write.
    // NOTE: the storage array is not reset; count_q/o_valid decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cap_q;
        end
    end

    assign o_data  = mem_q[rd_ptr_q];
    assign o_valid = (count_q != '0);
    assign o_count = count_q;
    assign o_state = state_q;
    assign o_err   = err_q;
    assign o_irq   = fifo_full || err_q;

endmodule

// File: tb/tb_trng_seq_ctrl.sv
// Testbench for trng_seq_ctrl: directed scenarios plus a randomized phase.
// A TRNG core model supplies words; a negedge monitor keeps a reference model
// of accepted words, health state and errors and compares the DUT each cycle.
module tb_trng_seq_ctrl;
    localparam int DEPTH   = 4;
    localparam int RST_CYC = 2;
    localparam int REP_LIM = 3;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       i_enable;
    logic                       i_calib_req;
    logic [31:0]                i_calib_cycles;
    logic                       i_pop;
    logic                       i_clr_err;
    logic                       i_trng_ready;
    logic [31:0]                i_trng_random;
    logic                       o_trng_rst;
    logic                       o_trng_en;
    logic                       o_trng_calib;
    logic                       o_trng_read;
    logic [31:0]                o_data;
    logic                       o_valid;
    logic [$clog2(DEPTH):0]     o_count;
    logic [2:0]                 o_state;
    logic                       o_err;
    logic                       o_irq;

    always #5 clk = ~clk;

    trng_seq_ctrl #(
        .FIFO_DEPTH (DEPTH),
        .RST_CYCLES (RST_CYC),
        .REP_LIMIT  (REP_LIM)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_enable       (i_enable),
        .i_calib_req    (i_calib_req),
        .i_calib_cycles (i_calib_cycles),
        .i_pop          (i_pop),
        .i_clr_err      (i_clr_err),
        .i_trng_ready   (i_trng_ready),
        .i_trng_random  (i_trng_random),
        .o_trng_rst     (o_trng_rst),
        .o_trng_en      (o_trng_en),
        .o_trng_calib   (o_trng_calib),
        .o_trng_read    (o_trng_read),
        .o_data         (o_data),
        .o_valid        (o_valid),
        .o_count        (o_count),
        .o_state        (o_state),
        .o_err          (o_err),
        .o_irq          (o_irq)
    );

    int          n_checks = 0;
    int          n_errors = 0;

    // Reference model state (owned by the monitor).
    logic [31:0] exp_q[$];
    logic [31:0] m_prev  = '0;
    int          m_rep   = 0;
    bit          m_err   = 1'b0;
    bit          m_fault = 1'b0;
    int          read_evt = 0;
    bit          pop_ok;
    bit          push_ok;

    // Stimulus state (owned by the driver).
    logic [31:0] word_q[$];
    int          read_ack   = 0;
    int          drain_hold = 0;
    bit          mon_en     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard: compare current outputs, then apply the effect of the coming edge.
    always @(negedge clk) begin
        if (mon_en) begin
            check("count", 32'(o_count), 32'(exp_q.size()));
            check("valid", 32'(o_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) check("data", o_data, exp_q[0]);
            check("err", 32'(o_err), 32'(m_err));
            check("irq", 32'(o_irq), 32'((exp_q.size() == DEPTH) || m_err));
            if (m_fault) check("fault_state", 32'(o_state), 32'd6);
            if (o_state == 3'd0 || o_state == 3'd6)
                check("trng_quiet", 32'({o_trng_rst, o_trng_en, o_trng_calib, o_trng_read}), 32'd0);

            if (!rst_n) begin
                exp_q.delete();
                m_rep   = 0;
                m_err   = 1'b0;
                m_fault = 1'b0;
            end else begin
                pop_ok  = i_pop && (exp_q.size() != 0);
                push_ok = 1'b0;
                if (m_fault && i_clr_err) begin
                    m_err   = 1'b0;
                    m_fault = 1'b0;
                    m_rep   = 0;
                end else if (!i_enable && !m_fault) begin
                    m_rep = 0;
                end
                if (o_trng_read === 1'b1) begin
                    check("read_en", 32'(o_trng_en), 32'd1);
                    if (m_rep > 0 && i_trng_random == m_prev) m_rep++;
                    else m_rep = 1;
                    m_prev = i_trng_random;
                    if (m_rep >= REP_LIM) begin
                        m_err   = 1'b1;
                        m_fault = 1'b1;
                    end else begin
                        push_ok = 1'b1;
                    end
                end
                if (pop_ok) void'(exp_q.pop_front());
                if (push_ok) exp_q.push_back(m_prev);
            end
        end
        if (o_trng_read === 1'b1) read_evt++;
    end

    // One clock step; clears pulses and runs the TRNG core model (hold word until read, then drop ready).
    task automatic step();
        @(posedge clk);
        #1;
        i_pop       = 1'b0;
        i_calib_req = 1'b0;
        i_clr_err   = 1'b0;
        if (i_trng_ready) begin
            if (read_evt != read_ack) begin
                if (drain_hold > 0) begin
                    drain_hold--;
                end else begin
                    i_trng_ready = 1'b0;
                    read_ack     = read_evt;
                end
            end
        end else if (word_q.size() != 0) begin
            i_trng_ready  = 1'b1;
            i_trng_random = word_q.pop_front();
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input string name);
        int n = 0;
        while (o_state !== s && n < 300) begin
            step();
            n++;
        end
        check(name, 32'(o_state), 32'(s));
    endtask

    task automatic drain_all();
        int n = 0;
        while ((o_valid || i_trng_ready || word_q.size() != 0) && n < 200) begin
            i_pop = o_valid;
            step();
            n++;
        end
        check("drain_empty", 32'(o_count), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          rc;
        int          cc;
        int          n;
        bit          order_bad;
        logic [31:0] last_word;
        logic [31:0] exp36 [4];

        exp36 = '{32'h11, 32'h22, 32'h33, 32'h44};
        rst_n          = 1'b0;
        i_enable       = 1'b0;
        i_calib_req    = 1'b0;
        i_calib_cycles = 32'd5;
        i_pop          = 1'b0;
        i_clr_err      = 1'b0;
        i_trng_ready   = 1'b0;
        i_trng_random  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Reset values.
        check("rst_state", 32'(o_state), 32'd0);
        check("rst_count", 32'(o_count), 32'd0);
        check("rst_err_irq", 32'({o_err, o_irq, o_valid}), 32'd0);
        check("rst_trng", 32'({o_trng_rst, o_trng_en, o_trng_calib, o_trng_read}), 32'd0);

        // Start-up: 2 reset cycles, 5 calibration cycles, then WAIT.
        i_enable  = 1'b1;
        rc        = 0;
        cc        = 0;
        order_bad = 1'b0;
        for (int i = 0; i < 40 && o_state != 3'd3; i++) begin
            step();
            if (o_trng_rst) begin
                rc++;
                if (cc > 0) order_bad = 1'b1;
            end
            if (o_trng_calib) cc++;
        end
        check("startup_rst_cycles", rc, 32'd2);
        check("startup_calib_cycles", cc, 32'd5);
        check("startup_order", 32'(order_bad), 32'd0);
        check("startup_wait", 32'(o_state), 32'd3);

        // Fill the FIFO, then back-pressure on the fifth word.
        word_q = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
        n = 0;
        while (o_count != 4 && n < 200) begin
            step();
            n++;
        end
        repeat (4) step();
        check("full_count", 32'(o_count), 32'd4);
        check("full_irq", 32'(o_irq), 32'd1);
        check("full_hold_wait", 32'(o_state), 32'd3);
        check("full_ready_pending", 32'(i_trng_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("pop_order", o_data, exp36[i]);
            i_pop = 1'b1;
            step();
        end
        drain_all();

        // Simultaneous push and pop at count 2; pop on empty.
        word_q = '{32'hA1, 32'hA2};
        n = 0;
        while (o_count != 2 && n < 200) begin
            step();
            n++;
        end
        word_q.push_back(32'hA3);
        wait_state(3'd4, "pushpop_read");
        check("pushpop_before", 32'(o_count), 32'd2);
        i_pop = 1'b1;
        step();
        check("pushpop_after", 32'(o_count), 32'd2);
        drain_all();
        i_pop = 1'b1;
        step();
        check("pop_empty_count", 32'(o_count), 32'd0);
        check("pop_empty_valid", 32'(o_valid), 32'd0);

        // Recalibration request during DRAIN.
        drain_hold = 2;
        word_q.push_back(32'hB1);
        wait_state(3'd5, "calreq_drain");
        i_calib_req = 1'b1;
        step();
        n = 0;
        while (o_state == 3'd5 && n < 20) begin
            step();
            n++;
        end
        check("calreq_wait", 32'(o_state), 32'd3);
        step();
        check("calreq_reset", 32'(o_state), 32'd1);
        repeat (RST_CYC) step();
        check("calreq_calib", 32'(o_state), 32'd2);

        // Three identical words trip the health test.
        word_q = '{32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        wait_state(3'd6, "health_fault");
        check("health_err", 32'(o_err), 32'd1);
        check("health_count", 32'(o_count), 32'd3);
        check("health_trng_off", 32'({o_trng_rst, o_trng_en, o_trng_calib, o_trng_read}), 32'd0);
        step();
        check("fault_sticky", 32'(o_state), 32'd6);
        i_clr_err = 1'b1;
        step();
        check("clr_idle", 32'(o_state), 32'd0);
        step();
        check("clr_reset", 32'(o_state), 32'd1);

        // Disable during CALIB with one word stored.
        i_pop = 1'b1;
        step();
        i_pop = 1'b1;
        step();
        wait_state(3'd2, "dis_calib");
        i_enable = 1'b0;
        step();
        check("dis_idle", 32'(o_state), 32'd0);
        check("dis_count", 32'(o_count), 32'd1);
        i_enable = 1'b1;

        // Reset in the middle of READ.
        word_q.push_back(32'hC1);
        wait_state(3'd4, "rst_read");
        rst_n = 1'b0;
        step();
        check("midrst_state", 32'(o_state), 32'd0);
        check("midrst_count", 32'(o_count), 32'd0);
        check("midrst_flags", 32'({o_valid, o_err, o_irq}), 32'd0);
        check("midrst_trng", 32'({o_trng_rst, o_trng_en, o_trng_calib, o_trng_read}), 32'd0);
        rst_n = 1'b1;

        // Randomized phase: random words with repeats, pops, recal requests and error clears.
        last_word = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (word_q.size() == 0 && !i_trng_ready && $urandom_range(3) == 0) begin
                if ($urandom_range(9) >= 3) last_word = $urandom;
                word_q.push_back(last_word);
                drain_hold = $urandom_range(2);
            end
            i_pop          = ($urandom_range(2) == 0);
            i_calib_req    = ($urandom_range(60) == 0);
            i_calib_cycles = 32'($urandom_range(3));
            if (m_fault && $urandom_range(3) == 0) i_clr_err = 1'b1;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
